// File: rtl/comparator_sweep_checker_if.sv
// Stimulus/response and status bundle between the sweep checker and its environment.
interface comparator_sweep_checker_if #(
  parameter int unsigned WIDTH = 2
);
  logic                 start;
  logic [WIDTH-1:0]     a_out;
  logic [WIDTH-1:0]     b_out;
  logic [2:0]           c_in;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [2*WIDTH:0]     err_count;
  logic [WIDTH-1:0]     first_err_a;
  logic [WIDTH-1:0]     first_err_b;
  logic [2:0]           first_err_c;

  // Checker side: drives operands and status, receives start and the comparator result.
  modport master (
    input  start, c_in,
    output a_out, b_out, busy, done, pass, err_count, first_err_a, first_err_b, first_err_c
  );

  // Environment side: host plus comparator under test.
  modport slave (
    output start, c_in,
    input  a_out, b_out, busy, done, pass, err_count, first_err_a, first_err_b, first_err_c
  );
endinterface

// File: rtl/comparator_sweep_checker.sv
// Exhaustive sweep checker for a magnitude comparator: drives every {A,B} pair, waits a settle
// time, samples C and compares it with a golden model, counting mismatches and capturing the
// first failing vector.
module comparator_sweep_checker #(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned SETTLE = 1
) (
  input logic                         clk,
  input logic                         rst,
  comparator_sweep_checker_if.master  bus
);

  localparam int unsigned IdxW = 2 * WIDTH;
  localparam int unsigned ErrW = 2 * WIDTH + 1;
  localparam int unsigned CntW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {StIdle, StWait, StCheck, StDone} state_e;

  state_e            state;
  logic [IdxW-1:0]   idx;
  logic [CntW-1:0]   cnt;
  logic [IdxW-1:0]   idx_inc;
  logic [2:0]        expected;
  logic              mismatch;

  // Golden model of the comparator for the vector currently driven.
  always_comb begin
    expected = 3'b000;
    expected[2] = bus.a_out > bus.b_out;
    expected[1] = bus.a_out == bus.b_out;
    expected[0] = bus.a_out < bus.b_out;
    mismatch = bus.c_in != expected;
    idx_inc = idx + IdxW'(1);
  end

  // Sweep FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= StIdle;
      idx             <= '0;
      cnt             <= '0;
      bus.a_out       <= '0;
      bus.b_out       <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.pass        <= 1'b0;
      bus.err_count   <= '0;
      bus.first_err_a <= '0;
      bus.first_err_b <= '0;
      bus.first_err_c <= '0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          if (bus.start) begin
            state           <= StWait;
            idx             <= '0;
            cnt             <= CntW'(SETTLE - 1);
            bus.a_out       <= '0;
            bus.b_out       <= '0;
            bus.busy        <= 1'b1;
            bus.done        <= 1'b0;
            bus.pass        <= 1'b0;
            bus.err_count   <= '0;
            bus.first_err_a <= '0;
            bus.first_err_b <= '0;
            bus.first_err_c <= '0;
          end
        end
        StWait: begin
          if (cnt == '0) begin
            state <= StCheck;
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        StCheck: begin
          if (mismatch) begin
            bus.err_count <= bus.err_count + ErrW'(1);
            if (bus.err_count == '0) begin
              bus.first_err_a <= bus.a_out;
              bus.first_err_b <= bus.b_out;
              bus.first_err_c <= bus.c_in;
            end
          end
          if (idx == '1) begin
            state    <= StDone;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            // Final vector's result is folded in here since err_count updates on this same edge.
            bus.pass <= !mismatch && (bus.err_count == '0);
          end else begin
            state                  <= StWait;
            idx                    <= idx_inc;
            {bus.a_out, bus.b_out} <= idx_inc;
            cnt                    <= CntW'(SETTLE - 1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_sweep_checker.sv
// Directed bench for comparator_sweep_checker: a behavioural comparator with selectable faults
// drives c_in; sweep results are checked against hand-computed expectations.
module tb_comparator_sweep_checker;

  localparam int unsigned WIDTH = 2;

  logic clk;
  logic rst;
  int   mode;   // 0 ideal, 1 stuck 010, 2 stuck 000, 3 gt/lt swapped
  int   errors;
  int   checks;

  comparator_sweep_checker_if #(.WIDTH(WIDTH)) bus ();

  comparator_sweep_checker #(.WIDTH(WIDTH), .SETTLE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator under test, with planted faults selected by mode.
  always_comb begin
    bus.c_in = 3'b000;
    case (mode)
      0: bus.c_in = {bus.a_out > bus.b_out, bus.a_out == bus.b_out, bus.a_out < bus.b_out};
      1: bus.c_in = 3'b010;
      2: bus.c_in = 3'b000;
      3: bus.c_in = {bus.a_out < bus.b_out, bus.a_out == bus.b_out, bus.a_out > bus.b_out};
      default: bus.c_in = 3'b111;
    endcase
  end

  typedef struct {
    int           mode;
    int           exp_err;
    logic [1:0]   exp_fa;
    logic [1:0]   exp_fb;
    logic [2:0]   exp_fc;
    logic         exp_pass;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, int'(bus.busy), 0);
    chk({tag, " done"}, int'(bus.done), 0);
    chk({tag, " pass"}, int'(bus.pass), 0);
    chk({tag, " err_count"}, int'(bus.err_count), 0);
    chk({tag, " a_out"}, int'(bus.a_out), 0);
    chk({tag, " b_out"}, int'(bus.b_out), 0);
    chk({tag, " first_err"}, int'({bus.first_err_a, bus.first_err_b, bus.first_err_c}), 0);
  endtask

  // Pulse start, confirm results are cleared on the accepting edge, then count cycles to done.
  // If repulse >= 0, start is asserted again for one cycle at that cycle count.
  task automatic run_sweep(input string tag, input int repulse, output int cycles);
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk({tag, " busy after start"}, int'(bus.busy), 1);
    chk({tag, " cleared err_count"}, int'(bus.err_count), 0);
    chk({tag, " cleared done"}, int'(bus.done), 0);
    cycles = 0;
    while (!bus.done && cycles < 200) begin
      bus.start = (cycles == repulse) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1 cycles++;
    end
    bus.start = 1'b0;
    chk({tag, " latency"}, cycles, 32);
  endtask

  initial begin
    int cyc;
    int guard;
    errors = 0;
    checks = 0;
    mode = 0;
    rst = 1'b1;
    bus.start = 1'b0;

    vecs[0] = '{mode: 0, exp_err: 0,  exp_fa: 2'd0, exp_fb: 2'd0, exp_fc: 3'b000, exp_pass: 1'b1};
    vecs[1] = '{mode: 1, exp_err: 12, exp_fa: 2'd0, exp_fb: 2'd1, exp_fc: 3'b010, exp_pass: 1'b0};
    vecs[2] = '{mode: 2, exp_err: 16, exp_fa: 2'd0, exp_fb: 2'd0, exp_fc: 3'b000, exp_pass: 1'b0};
    vecs[3] = '{mode: 3, exp_err: 12, exp_fa: 2'd0, exp_fb: 2'd1, exp_fc: 3'b100, exp_pass: 1'b0};

    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");

    // rst and start together: rst wins.
    bus.start = 1'b1;
    @(posedge clk);
    #1 chk("rst+start busy", int'(bus.busy), 0);
    bus.start = 1'b0;
    rst = 1'b0;

    // Table-driven sweeps; each later row also exercises a restart from DONE.
    for (int i = 0; i < 4; i++) begin
      mode = vecs[i].mode;
      run_sweep($sformatf("vec%0d", i), -1, cyc);
      chk($sformatf("vec%0d done", i), int'(bus.done), 1);
      chk($sformatf("vec%0d busy", i), int'(bus.busy), 0);
      chk($sformatf("vec%0d pass", i), int'(bus.pass), int'(vecs[i].exp_pass));
      chk($sformatf("vec%0d err_count", i), int'(bus.err_count), vecs[i].exp_err);
      chk($sformatf("vec%0d first_err_a", i), int'(bus.first_err_a), int'(vecs[i].exp_fa));
      chk($sformatf("vec%0d first_err_b", i), int'(bus.first_err_b), int'(vecs[i].exp_fb));
      chk($sformatf("vec%0d first_err_c", i), int'(bus.first_err_c), int'(vecs[i].exp_fc));
    end

    // Done is held and a_out/b_out keep the last vector (3,3).
    repeat (3) @(posedge clk);
    #1 chk("done held", int'(bus.done), 1);
    chk("last vector held", int'({bus.a_out, bus.b_out}), 15);

    // Reset mid-sweep at idx 5, then a clean ideal sweep.
    mode = 0;
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    guard = 0;
    while ({bus.a_out, bus.b_out} != 4'd5 && guard < 100) begin
      @(posedge clk);
      #1 guard++;
    end
    chk("reach idx5", int'(guard < 100), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 chk_all_zero("midsweep rst");
    rst = 1'b0;
    run_sweep("post-rst", -1, cyc);
    chk("post-rst pass", int'(bus.pass), 1);
    chk("post-rst err_count", int'(bus.err_count), 0);

    // Start re-pulsed while busy is ignored.
    mode = 1;
    run_sweep("repulse", 7, cyc);
    chk("repulse err_count", int'(bus.err_count), 12);
    chk("repulse first_err_b", int'(bus.first_err_b), 1);
    chk("repulse pass", int'(bus.pass), 0);

    // Restart from DONE with the same fault reproduces the same count.
    run_sweep("rerun", -1, cyc);
    chk("rerun err_count", int'(bus.err_count), 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
